// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: frog position, collision, lives, score and
// difficulty control for the lane-crossing game.
module frog_game_ctrl #(
  parameter int LIVES     = 3,
  parameter int HIT_HOLD  = 1000,
  parameter int START_COL = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic [15:0][15:0] occ,
  output logic [3:0]        frog_row,
  output logic [3:0]        frog_col,
  output logic [1:0]        lives,
  output logic [7:0]        score,
  output logic [1:0]        difficulty,
  output logic              hit_flash,
  output logic              game_over
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    WIN  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HIT_HOLD - 1);
  localparam logic [3:0]  COL0      = 4'(START_COL);
  localparam logic [1:0]  LIVES0    = 2'(LIVES);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  diff_q, diff_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  hist_q, hist_d;
  logic        hit_q, hit_d;
  logic        over_q, over_d;

  logic [3:0] btn;
  logic [3:0] press;
  logic       mv_up, mv_dn, mv_lt, mv_rt;
  logic       car;

  assign btn   = {btn_right, btn_left, btn_down, btn_up};
  assign press = btn & ~hist_q;
  assign car   = occ[row_q][col_q];

  // One move per cycle: up beats down beats left beats right.
  assign mv_up = press[0];
  assign mv_dn = press[1] & ~press[0];
  assign mv_lt = press[2] & ~press[1] & ~press[0];
  assign mv_rt = press[3] & ~press[2] & ~press[1] & ~press[0];

  // Next-state, position, lives, score and flag computation.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lives_d = lives_q;
    score_d = score_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    hist_d  = btn;
    unique case (state_q)
      PLAY: begin
        if (car) begin
          state_d = HIT;
          cnt_d   = '0;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end else if (row_q == 4'd15) begin
          state_d = WIN;
        end else begin
          unique case (1'b1)
            mv_up: if (row_q != 4'd15) row_d = row_q + 4'd1;
            mv_dn: if (row_q != 4'd0)  row_d = row_q - 4'd1;
            mv_lt: if (col_q != 4'd15) col_d = col_q + 4'd1;
            mv_rt: if (col_q != 4'd0)  col_d = col_q - 4'd1;
            default: ;
          endcase
        end
      end
      HIT: begin
        if (lives_q == 2'd0) begin
          state_d = OVER;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = PLAY;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = COL0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WIN: begin
        state_d = PLAY;
        row_d   = '0;
        col_d   = COL0;
        if (score_q != 8'd255) score_d = score_q + 8'd1;
        if (diff_q != 2'd3)    diff_d  = diff_q + 2'd1;
      end
      OVER: begin
        lives_d = '0;
      end
    endcase
    hit_d  = (state_d == HIT);
    over_d = (state_d == OVER);
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      row_q   <= '0;
      col_q   <= COL0;
      lives_q <= LIVES0;
      score_q <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      hist_q  <= btn;
      hit_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lives_q <= lives_d;
      score_q <= score_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      hit_q   <= hit_d;
      over_q  <= over_d;
    end
  end

  assign frog_row   = row_q;
  assign frog_col   = col_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign difficulty = diff_q;
  assign hit_flash  = hit_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb_frog_game_ctrl: directed checks of movement, collision,
// game over, win and saturation behaviour.
module tb_frog_game_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic              btn_up, btn_down, btn_left, btn_right;
  logic [15:0][15:0] occ;
  logic [3:0]        frog_row, frog_col;
  logic [1:0]        lives;
  logic [7:0]        score;
  logic [1:0]        difficulty;
  logic              hit_flash, game_over;

  int total = 0;
  int bad   = 0;

  frog_game_ctrl #(
    .LIVES(3),
    .HIT_HOLD(4),
    .START_COL(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .occ(occ),
    .frog_row(frog_row),
    .frog_col(frog_col),
    .lives(lives),
    .score(score),
    .difficulty(difficulty),
    .hit_flash(hit_flash),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right; one press then one release cycle
  task automatic press(input int dir);
    case (dir)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    step();
    btn_up = 1'b0; btn_down = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0;
    step();
  endtask

  task automatic pos(input string tag, input int r, input int c);
    chk({tag, "_row"}, 32'(frog_row), 32'(r));
    chk({tag, "_col"}, 32'(frog_col), 32'(c));
  endtask

  task automatic win_run(input int sc, input int df);
    for (int i = 0; i < 15; i++) press(0);
    chk("win_row15", 32'(frog_row), 32'd15);
    chk("win_score_pending", 32'(score), 32'(sc - 1));
    step();
    chk("win_score", 32'(score), 32'(sc));
    chk("win_diff", 32'(difficulty), 32'(df));
    pos("win_home", 0, 7);
  endtask

  initial begin
    reset = 1'b1;
    btn_up = 1'b1; btn_down = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0;
    occ = '0;
    step();
    step();
    pos("rst", 0, 7);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_diff", 32'(difficulty), 32'd0);
    chk("rst_hit", 32'(hit_flash), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);

    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_row", 32'(frog_row), 32'd0);
    end
    btn_up = 1'b0;
    step();
    pos("held_release", 0, 7);

    for (int i = 0; i < 3; i++) press(1);
    pos("down_clamp", 0, 7);

    for (int i = 0; i < 20; i++) begin
      press(3);
      if (i == 2) chk("right_3", 32'(frog_col), 32'd4);
      if (i == 6) chk("right_7", 32'(frog_col), 32'd0);
    end
    chk("right_clamp", 32'(frog_col), 32'd0);

    btn_up = 1'b1; btn_left = 1'b1;
    step();
    pos("up_left", 1, 0);
    btn_up = 1'b0; btn_left = 1'b0;
    step();
    for (int i = 0; i < 7; i++) press(2);
    pos("left_7", 1, 7);

    occ[1][7] = 1'b1;
    step();
    chk("hit1_flash", 32'(hit_flash), 32'd1);
    chk("hit1_lives", 32'(lives), 32'd2);
    occ = '0;
    btn_up = 1'b1;
    step();
    chk("hit1_c2", 32'(hit_flash), 32'd1);
    btn_up = 1'b0;
    step();
    chk("hit1_c3", 32'(hit_flash), 32'd1);
    btn_left = 1'b1;
    step();
    chk("hit1_c4", 32'(hit_flash), 32'd1);
    btn_left = 1'b0;
    step();
    chk("hit1_end", 32'(hit_flash), 32'd0);
    pos("hit1_home", 0, 7);
    step();
    pos("hit1_nomove", 0, 7);

    occ[1][7] = 1'b1;
    btn_up = 1'b1;
    step();
    pos("into_car", 1, 7);
    chk("into_car_nohit", 32'(hit_flash), 32'd0);
    btn_up = 1'b0;
    step();
    chk("hit2_flash", 32'(hit_flash), 32'd1);
    chk("hit2_lives", 32'(lives), 32'd1);
    occ = '0;
    for (int i = 0; i < 3; i++) step();
    chk("hit2_c4", 32'(hit_flash), 32'd1);
    step();
    chk("hit2_end", 32'(hit_flash), 32'd0);
    pos("hit2_home", 0, 7);

    press(0);
    press(0);
    press(3);
    press(3);
    pos("stand", 2, 5);
    occ[2][5] = 1'b1;
    step();
    chk("hit3_flash", 32'(hit_flash), 32'd1);
    chk("hit3_lives", 32'(lives), 32'd0);
    chk("hit3_over", 32'(game_over), 32'd0);
    step();
    chk("over_flash", 32'(hit_flash), 32'd0);
    chk("over_set", 32'(game_over), 32'd1);
    occ = '1;
    press(0);
    occ = '0;
    press(2);
    pos("over_hold", 2, 5);
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_score", 32'(score), 32'd0);
    chk("over_stay", 32'(game_over), 32'd1);
    chk("over_noflash", 32'(hit_flash), 32'd0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    pos("rst2", 0, 7);
    chk("rst2_lives", 32'(lives), 32'd3);
    chk("rst2_over", 32'(game_over), 32'd0);
    step();

    win_run(1, 1);
    win_run(2, 2);
    win_run(3, 3);
    win_run(4, 3);
    chk("final_lives", 32'(lives), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frog_game_ctrl.md
# frog_game_ctrl

Player-side game controller for the lane-crossing game. It sits directly downstream of the car/lane shifter and consumes the per-row car occupancy bitmaps. It also tracks the frog position from the four direction buttons and detects collisions and goal arrival. It maintains lives and score, and drives the `difficulty` code back into the lane shifter.

## Interface

**Parameters**
- `LIVES`, default 3 — starting lives; legal range 1..3.
- `HIT_HOLD`, default 1000 — clock cycles spent in HIT; legal range 1..65535.
- `START_COL`, default 7 — frog column after reset, hit recovery and win.

**Ports**
- `clk`  in  1  — clock.
- `reset`  in  1  — reset, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  — synchronized, debounced button levels, active-high.
- `occ`  in  [15:0][15:0]  — car occupancy, `occ[row][col]`.
  - Rows 1–7 and 10–14 come from the lane bitmaps.
  - Rows 0, 8, 9 and 15 are tied 0 at top level.
- `frog_row`  out  4  — frog row; 0 is the start row, 15 is the goal row.
- `frog_col`  out  4  — frog column.
- `lives`  out  2  — remaining lives.
- `score`  out  8  — completed crossings, saturating at 255.
- `difficulty`  out  2  — to the lane shifter; 0 is slowest.
- `hit_flash`  out  1  — high while in HIT.
- `game_over`  out  1  — high while in OVER.

## Operation

**Reset values**
- `frog_row`=0, `frog_col`=`START_COL`, `lives`=`LIVES`, `score`=0, `difficulty`=0.
- `hit_flash`=0, `game_over`=0, state=PLAY, hold counter=0.
- Button history registers load the current button levels, so a button held through reset produces no move.

**Edge detect**
- A press is a rising edge: `btn` high and its history register low. History registers update every cycle in every state.

**State machine** (states PLAY, HIT, WIN, OVER)
- **PLAY.** Each cycle, evaluate in this priority order:
  1. If `occ[frog_row][frog_col]`=1: go to HIT. `lives` decrements. Any press in the same cycle is discarded.
  2. Else if `frog_row`=15: go to WIN.
  3. Else apply at most one press, priority up > down > left > right.
     - up: row+1, clamped at 15.
     - down: row−1, clamped at 0.
     - left: col+1, clamped at 15.
     - right: col−1, clamped at 0.
     - A clamped move leaves the position unchanged.
- **HIT.**
  - If `lives` is 0 on entry: go to OVER on the next cycle.
  - Otherwise the counter counts `HIT_HOLD` cycles, then the frog returns to row 0 / `START_COL`, the counter clears, and the state returns to PLAY.
  - Presses are ignored.
- **WIN.** One cycle only:
  - `score`+1, saturating at 255.
  - `difficulty`+1, saturating at 3.
  - Frog returns to row 0 / `START_COL`.
  - Next state is PLAY. Presses are ignored.
- **OVER.**
  - Terminal until `reset`; presses are ignored.
  - Position, `score` and `difficulty` hold; `lives`=0.

**Width rules**
- `lives` never underflows; decrement happens only from a nonzero value.
- The hold counter is 16 bits.

**Reset mid-operation**
- `reset` has priority over every state and over an in-progress hold, and restores all reset values on the next edge.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- **Move latency.** A press visible at edge N (history low, level high) updates `frog_row`/`frog_col` at edge N. A new press needs the button released for ≥1 cycle.
- **Collision latency.** Position and `occ` are sampled at edge N; at the same edge, state=HIT, `hit_flash`=1 and `lives` is decremented.
  - A car shifting onto a stationary frog is caught on the first cycle `occ` shows it.
  - A frog moving onto a car is caught one cycle after the move.
- **HIT duration.** `hit_flash` is high for exactly `HIT_HOLD` cycles, then PLAY resumes with the frog at start. The first post-HIT collision check happens at start position, where row 0 is always clear.
- **Final hit.** When the last life is lost, `hit_flash` is high 1 cycle, then `game_over`=1 permanently.
- **WIN.** The state is WIN for 1 cycle after `frog_row` reads 15. `score` and `difficulty` update on the WIN→PLAY edge.
- `difficulty` changes only on that WIN→PLAY edge and on reset; the lane shifter may sample it at any time.

## Test plan

- **Reset and held button:** hold `btn_up`=1 through reset and release it 5 cycles later → `frog_row`=0, `frog_col`=7, `lives`=3, `score`=0, `difficulty`=0 throughout; no move.
- **Movement and clamping:** 3 `btn_down` pulses at row 0 → row stays 0. 20 `btn_right` pulses → col 0 after 7 pulses, then holds. `btn_up`+`btn_left` rising on the same cycle → row+1, col unchanged.
- **Collision:** frog at row 1 col 7, set `occ[1][7]`=1 → next edge: `hit_flash`=1, `lives`=2. With `HIT_HOLD`=4, `hit_flash` high exactly 4 cycles, frog back at 0/7, presses during HIT ignored.
- **Game over:** three collisions → `lives` 3→2→1→0. After the third, `hit_flash` is high 1 cycle, then `game_over`=1. Further presses and `occ` changes cause no output change; `reset` restores PLAY.
- **Win and saturation:** walk the frog to row 15 with all `occ`=0 → 1 WIN cycle, `score`=1, `difficulty`=1, frog at 0/7. Repeat 4 times → `difficulty` stays at 3; `score`=4.
- **Move into car vs. car onto frog:** with `occ[1][7]`=1, press up from row 0 → row becomes 1, HIT follows one edge later. Separately, a stationary frog at 2/5 with `occ[2][5]` going 0→1 → HIT on the first sampling edge.
